// File: rtl/spi_byte_tx.sv
// spi_byte_tx: byte-serial SPI mode-0 master; SPI_FRAME_CS_EN holds cs_n low across a multi-byte frame.
module spi_byte_tx #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 5,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic       baseClk,
    input  logic       hard_Clr,
    input  logic [7:0] data,
    input  logic       sendEnable,
    output logic       sendBusy,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       frame_done
);
    localparam int DW = $clog2(CLK_DIV + 1);

    if (CLK_DIV < 1 || CLK_DIV > 255 || FRAME_BYTES < 1 || GAP_TIMEOUT < 1) begin : g_bad_param
        $error("spi_byte_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [3:0]    hp;
    logic [7:0]    shreg;
    logic          armed;
    logic          accept, div_end, frame_end, gap_end;

    assign accept  = (state == IDLE || state == GAP) && sendEnable && armed;
    assign div_end = div_cnt == DW'(CLK_DIV - 1);

`ifdef SPI_FRAME_CS_EN
    localparam int BW = $clog2(FRAME_BYTES + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    assign frame_end = byte_cnt == BW'(FRAME_BYTES - 1);
    assign gap_end   = gap_cnt == GW'(GAP_TIMEOUT - 1);
    always_ff @(posedge baseClk) begin
        if (hard_Clr) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            byte_cnt <= (state == TRAIL && div_end) ? (frame_end ? '0 : byte_cnt + 1'b1)
                      : (state == GAP && state_nxt == IDLE) ? '0 : byte_cnt;
            gap_cnt  <= (state == GAP && state_nxt == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end
`else
    assign frame_end = 1'b1;
    assign gap_end   = 1'b1;
`endif

    always_ff @(posedge baseClk) begin
        if (hard_Clr) begin
            state      <= IDLE;
            div_cnt    <= '0;
            hp         <= '0;
            shreg      <= '0;
            armed      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= !sendEnable ? 1'b1 : accept ? 1'b0 : armed;
            frame_done <= state == TRAIL && div_end && frame_end;
            div_cnt    <= (state == IDLE || state == GAP || div_end) ? '0 : div_cnt + 1'b1;
            hp         <= (state == SHIFT && state_nxt == SHIFT) ? hp + 4'(div_end) : '0;
            // even half-periods are SCK high; leaving one is a falling edge
            shreg      <= accept ? data
                        : (state == SHIFT && div_end && !hp[0]) ? {shreg[6:0], 1'b0} : shreg;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = accept ? LEAD : IDLE;
            LEAD:    state_nxt = div_end ? SHIFT : LEAD;
            SHIFT:   state_nxt = (div_end && hp == 4'd15) ? TRAIL : SHIFT;
            TRAIL:   state_nxt = !div_end ? TRAIL : frame_end ? IDLE : GAP;
            GAP:     state_nxt = accept ? LEAD : gap_end ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sendBusy = state == LEAD || state == SHIFT || state == TRAIL;
        spi_cs_n = state == IDLE;
        spi_sck  = state == SHIFT && !hp[0];
        spi_mosi = shreg[7];
    end
endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: directed vector bench for spi_byte_tx; expectations follow SPI_FRAME_CS_EN.
module tb_spi_byte_tx;
    logic       baseClk = 1'b0;
    logic       hard_Clr = 1'b1;
    logic [7:0] data = 8'h00;
    logic       sendEnable = 1'b0;
    logic       sendBusy, spi_sck, spi_mosi, spi_cs_n, frame_done;

    spi_byte_tx #(.CLK_DIV(4), .FRAME_BYTES(5), .GAP_TIMEOUT(16)) dut (
        .baseClk(baseClk), .hard_Clr(hard_Clr), .data(data), .sendEnable(sendEnable),
        .sendBusy(sendBusy), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .frame_done(frame_done)
    );

    always #5 baseClk = ~baseClk;

    logic [7:0] rx = 8'h00;
    logic       sck_q = 1'b0, cs_q = 1'b1, busy_q = 1'b0;
    int rises = 0, busy_cyc = 0, cs_cyc = 0, fd_cnt = 0, fd_bad = 0, cs_rise = 0;

    always @(negedge baseClk) begin
        if (spi_sck && !sck_q) begin
            rx    <= {rx[6:0], spi_mosi};
            rises <= rises + 1;
        end
        if (sendBusy) busy_cyc <= busy_cyc + 1;
        if (!spi_cs_n) cs_cyc <= cs_cyc + 1;
        if (spi_cs_n && !cs_q) cs_rise <= cs_rise + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_done && !(busy_q && !sendBusy)) fd_bad <= fd_bad + 1;
        sck_q  <= spi_sck;
        cs_q   <= spi_cs_n;
        busy_q <= sendBusy;
    end

    int passed = 0, total = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    task automatic tick();
        @(posedge baseClk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sendBusy || !spi_cs_n) && n < 400) begin
            tick();
            n++;
        end
        check("idle_wait_bound", int'(n < 400), 1);
        tick();
        tick();
    endtask

    task automatic send_wait(input logic [7:0] d);
        int n = 0;
        data = d;
        sendEnable = 1'b1;
        tick();
        sendEnable = 1'b0;
        while (sendBusy && n < 200) begin
            tick();
            n++;
        end
        check("busy_wait_bound", int'(n < 200), 1);
    endtask

    typedef struct {
        logic [7:0] d;
        int         busy;
        int         cs;
        int         fd;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int r0, b0, c0, f0, cr0, fb0, n;
`ifdef SPI_FRAME_CS_EN
        localparam int CS_SINGLE = 88, FD_SINGLE = 0;
`else
        localparam int CS_SINGLE = 72, FD_SINGLE = 1;
`endif
        vecs[0] = '{8'hA5, 72, CS_SINGLE, FD_SINGLE};
        vecs[1] = '{8'h00, 72, CS_SINGLE, FD_SINGLE};
        vecs[2] = '{8'hFF, 72, CS_SINGLE, FD_SINGLE};
        vecs[3] = '{8'h81, 72, CS_SINGLE, FD_SINGLE};
        vecs[4] = '{8'h3C, 72, CS_SINGLE, FD_SINGLE};

        tick();
        tick();
        check("rst_busy", int'(sendBusy), 0);
        check("rst_sck", int'(spi_sck), 0);
        check("rst_mosi", int'(spi_mosi), 0);
        check("rst_cs_n", int'(spi_cs_n), 1);
        check("rst_frame_done", int'(frame_done), 0);
        hard_Clr = 1'b0;
        tick();

        foreach (vecs[i]) begin
            r0 = rises; b0 = busy_cyc; c0 = cs_cyc; f0 = fd_cnt;
            data = vecs[i].d;
            sendEnable = 1'b1;
            tick();
            sendEnable = 1'b0;
            check("accept_busy", int'(sendBusy), 1);
            check("accept_cs_n", int'(spi_cs_n), 0);
            check("accept_mosi", int'(spi_mosi), int'(vecs[i].d[7]));
            wait_idle();
            check("vec_rx", int'(rx), int'(vecs[i].d));
            check("vec_rises", rises - r0, 8);
            check("vec_busy_cycles", busy_cyc - b0, vecs[i].busy);
            check("vec_cs_cycles", cs_cyc - c0, vecs[i].cs);
            check("vec_frame_done", fd_cnt - f0, vecs[i].fd);
        end
        check("fd_align_single", fd_bad, 0);

        // level held high sends only one byte
        r0 = rises;
        data = 8'h3C;
        sendEnable = 1'b1;
        repeat (200) tick();
        check("held_one_byte", rises - r0, 8);
        check("held_rx", int'(rx), 8'h3C);
        sendEnable = 1'b0;
        tick();
        sendEnable = 1'b1;
        tick();
        sendEnable = 1'b0;
        wait_idle();
        check("rearm_second_byte", rises - r0, 16);

        // hard_Clr at the fourth SCK rise aborts the byte
        r0 = rises;
        data = 8'hA5;
        sendEnable = 1'b1;
        tick();
        sendEnable = 1'b0;
        n = 0;
        while (rises - r0 < 4 && n < 100) begin
            tick();
            n++;
        end
        check("clr_rise_bound", int'(n < 100), 1);
        hard_Clr = 1'b1;
        tick();
        check("clr_cs_n", int'(spi_cs_n), 1);
        check("clr_sck", int'(spi_sck), 0);
        check("clr_busy", int'(sendBusy), 0);
        check("clr_mosi", int'(spi_mosi), 0);
        hard_Clr = 1'b0;
        tick();
        tick();
        r0 = rises;
        b0 = busy_cyc;
        data = 8'h5A;
        sendEnable = 1'b1;
        tick();
        sendEnable = 1'b0;
        wait_idle();
        check("clr_fresh_rx", int'(rx), 8'h5A);
        check("clr_fresh_rises", rises - r0, 8);
        check("clr_fresh_busy", busy_cyc - b0, 72);

`ifdef SPI_FRAME_CS_EN
        // full frame with short gaps
        r0 = rises; f0 = fd_cnt; cr0 = cs_rise; fb0 = fd_bad;
        send_wait(8'hFF); repeat (3) tick();
        send_wait(8'h10); repeat (3) tick();
        send_wait(8'h27); repeat (3) tick();
        send_wait(8'h00); repeat (3) tick();
        send_wait(8'h00);
        wait_idle();
        check("frame_rises", rises - r0, 40);
        check("frame_cs_rises", cs_rise - cr0, 1);
        check("frame_done_count", fd_cnt - f0, 1);
        check("frame_done_align", fd_bad - fb0, 0);

        // gap timeout after two bytes, then a fresh frame count
        f0 = fd_cnt;
        send_wait(8'h12); repeat (3) tick();
        send_wait(8'h34);
        n = 0;
        while (!spi_cs_n && n < 100) begin
            tick();
            n++;
        end
        check("gap_timeout_cycles", n, 16);
        tick();
        check("gap_no_frame_done", fd_cnt - f0, 0);
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            send_wait(8'(k));
            repeat (3) tick();
        end
        check("restart_no_early_done", fd_cnt - f0, 0);
        check("restart_cs_low", int'(spi_cs_n), 0);
        send_wait(8'h55);
        wait_idle();
        check("restart_frame_done", fd_cnt - f0, 1);
`else
        // every byte frames itself
        f0 = fd_cnt; cr0 = cs_rise; fb0 = fd_bad;
        send_wait(8'h81);
        tick();
        tick();
        check("b2b_rx0", int'(rx), 8'h81);
        check("b2b_cs_between", int'(spi_cs_n), 1);
        send_wait(8'h7E);
        wait_idle();
        check("b2b_rx1", int'(rx), 8'h7E);
        check("b2b_cs_rises", cs_rise - cr0, 2);
        check("b2b_frame_done", fd_cnt - f0, 2);
        check("b2b_fd_align", fd_bad - fb0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
